// File: rtl/decode_stage.sv
// MIPS decode/register-file stage: splits R-type fields, reads a 32x32 register file
// with write bypass, and presents registered operands to execute one cycle later.
module decode_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       instr,
  input  logic              stall,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] rs_val,
  output logic [DATA_W-1:0] rt_val,
  output logic [5:0]        func,
  output logic [4:0]        sa,
  output logic [4:0]        rd,
  output logic              illegal,
  output logic [7:0]        illegal_count
);

  logic [DATA_W-1:0] rf_q [NREGS];

  logic [5:0] op_f;
  logic [4:0] rs_f, rt_f, rd_f, sa_f;
  logic [5:0] func_f;
  logic       wb_live;
  logic [DATA_W-1:0] rs_rd, rt_rd;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] rs_val_q, rs_val_d, rt_val_q, rt_val_d;
  logic [5:0]        func_q, func_d;
  logic [4:0]        sa_q, sa_d, rd_q, rd_d;
  logic [4:0]        rs_idx_q, rs_idx_d, rt_idx_q, rt_idx_d;
  logic              illegal_q, illegal_d;
  logic [7:0]        cnt_q, cnt_d;

  assign op_f    = instr[31:26];
  assign rs_f    = instr[25:21];
  assign rt_f    = instr[20:16];
  assign rd_f    = instr[15:11];
  assign sa_f    = instr[10:6];
  assign func_f  = instr[5:0];
  assign wb_live = wb_en && (wb_addr != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_q <= '{default: '0};
    end else if (wb_live) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  // Register 0 is forced to zero on read; wb_live already excludes address 0.
  always_comb begin
    rs_rd = (rs_f == '0) ? '0 : rf_q[rs_f];
    rt_rd = (rt_f == '0) ? '0 : rf_q[rt_f];
    if (wb_live && (wb_addr == rs_f)) rs_rd = wb_data;
    if (wb_live && (wb_addr == rt_f)) rt_rd = wb_data;
  end

  always_comb begin
    valid_d   = valid_q;
    rs_val_d  = rs_val_q;
    rt_val_d  = rt_val_q;
    func_d    = func_q;
    sa_d      = sa_q;
    rd_d      = rd_q;
    rs_idx_d  = rs_idx_q;
    rt_idx_d  = rt_idx_q;
    illegal_d = 1'b0;
    cnt_d     = cnt_q;
    if (!stall) begin
      valid_d  = in_valid && (op_f == '0);
      rs_val_d = rs_rd;
      rt_val_d = rt_rd;
      func_d   = func_f;
      sa_d     = sa_f;
      rd_d     = rd_f;
      rs_idx_d = rs_f;
      rt_idx_d = rt_f;
      if (in_valid && (op_f != '0)) begin
        illegal_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + 8'd1;
      end
    end else begin
      // Held operands track writeback so execute sees current values when the stall ends.
      if (wb_live && (wb_addr == rs_idx_q)) rs_val_d = wb_data;
      if (wb_live && (wb_addr == rt_idx_q)) rt_val_d = wb_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      rs_val_q  <= '0;
      rt_val_q  <= '0;
      func_q    <= '0;
      sa_q      <= '0;
      rd_q      <= '0;
      rs_idx_q  <= '0;
      rt_idx_q  <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      rs_val_q  <= rs_val_d;
      rt_val_q  <= rt_val_d;
      func_q    <= func_d;
      sa_q      <= sa_d;
      rd_q      <= rd_d;
      rs_idx_q  <= rs_idx_d;
      rt_idx_q  <= rt_idx_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid     = valid_q;
  assign rs_val        = rs_val_q;
  assign rt_val        = rt_val_q;
  assign func          = func_q;
  assign sa            = sa_q;
  assign rd            = rd_q;
  assign illegal       = illegal_q;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed vector bench for decode_stage: table of per-cycle stimulus and expected
// outputs, plus hand-written saturation and asynchronous-reset sequences.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] instr;
  logic        stall;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic [31:0] rs_val, rt_val;
  logic [5:0]  func;
  logic [4:0]  sa, rd;
  logic        illegal;
  logic [7:0]  illegal_count;

  int checks = 0;
  int errors = 0;

  decode_stage #(.DATA_W(32), .NREGS(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .instr(instr), .stall(stall),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
    .rs_val(rs_val), .rt_val(rt_val), .func(func), .sa(sa), .rd(rd),
    .illegal(illegal), .illegal_count(illegal_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        iv;
    logic [31:0] ins;
    logic        st;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        e_valid;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic [5:0]  e_func;
    logic [4:0]  e_sa;
    logic [4:0]  e_rd;
    logic        e_ill;
    logic [7:0]  e_cnt;
  } vec_t;

  function automatic logic [31:0] mk_r(input logic [4:0] rs_i, input logic [4:0] rt_i,
                                       input logic [4:0] rd_i, input logic [4:0] sa_i,
                                       input logic [5:0] fn_i);
    return {6'd0, rs_i, rt_i, rd_i, sa_i, fn_i};
  endfunction

  function automatic vec_t mkv(input logic iv, input logic [31:0] ins, input logic st,
                               input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic ev, input logic [31:0] ers, input logic [31:0] ert,
                               input logic [5:0] ef, input logic [4:0] esa, input logic [4:0] erd,
                               input logic eil, input logic [7:0] ec);
    vec_t v;
    v.iv = iv; v.ins = ins; v.st = st; v.we = we; v.wa = wa; v.wd = wd;
    v.e_valid = ev; v.e_rs = ers; v.e_rt = ert; v.e_func = ef; v.e_sa = esa;
    v.e_rd = erd; v.e_ill = eil; v.e_cnt = ec;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [31:0] ers,
                           input logic [31:0] ert, input logic [5:0] ef, input logic [4:0] esa,
                           input logic [4:0] erd, input logic eil, input logic [7:0] ec);
    check({tag, " out_valid"},     {31'd0, out_valid},     {31'd0, ev});
    check({tag, " rs_val"},        rs_val,                 ers);
    check({tag, " rt_val"},        rt_val,                 ert);
    check({tag, " func"},          {26'd0, func},          {26'd0, ef});
    check({tag, " sa"},            {27'd0, sa},            {27'd0, esa});
    check({tag, " rd"},            {27'd0, rd},            {27'd0, erd});
    check({tag, " illegal"},       {31'd0, illegal},       {31'd0, eil});
    check({tag, " illegal_count"}, {24'd0, illegal_count}, {24'd0, ec});
  endtask

  task automatic drive(input logic iv, input logic [31:0] ins, input logic st,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    in_valid = iv; instr = ins; stall = st; wb_en = we; wb_addr = wa; wb_data = wd;
  endtask

  localparam logic [31:0] LW = 32'h8C22_0004;

  vec_t tbl [18];
  logic [7:0] exp_cnt;

  initial begin
    tbl[0]  = mkv(1'b0, 32'h0, 1'b0, 1'b1, 5'd5, 32'h0000_0007,
                  1'b0, 32'h0, 32'h0, 6'h00, 5'd0, 5'd0, 1'b0, 8'd0);
    tbl[1]  = mkv(1'b0, 32'h0, 1'b0, 1'b1, 5'd6, 32'hFFFF_FFF9,
                  1'b0, 32'h0, 32'h0, 6'h00, 5'd0, 5'd0, 1'b0, 8'd0);
    tbl[2]  = mkv(1'b1, 32'h00A6_3820, 1'b0, 1'b0, 5'd0, 32'h0,
                  1'b1, 32'h7, 32'hFFFF_FFF9, 6'h20, 5'd0, 5'd7, 1'b0, 8'd0);
    tbl[3]  = mkv(1'b1, mk_r(5'd5, 5'd6, 5'd3, 5'd4, 6'h22), 1'b0, 1'b1, 5'd5, 32'h1234_5678,
                  1'b1, 32'h1234_5678, 32'hFFFF_FFF9, 6'h22, 5'd4, 5'd3, 1'b0, 8'd0);
    tbl[4]  = mkv(1'b1, mk_r(5'd6, 5'd5, 5'd8, 5'd0, 6'h25), 1'b0, 1'b0, 5'd0, 32'h0,
                  1'b1, 32'hFFFF_FFF9, 32'h1234_5678, 6'h25, 5'd0, 5'd8, 1'b0, 8'd0);
    tbl[5]  = mkv(1'b1, mk_r(5'd0, 5'd0, 5'd1, 5'd0, 6'h20), 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF,
                  1'b1, 32'h0, 32'h0, 6'h20, 5'd0, 5'd1, 1'b0, 8'd0);
    tbl[6]  = mkv(1'b1, mk_r(5'd0, 5'd0, 5'd2, 5'd31, 6'h00), 1'b0, 1'b0, 5'd0, 32'h0,
                  1'b1, 32'h0, 32'h0, 6'h00, 5'd31, 5'd2, 1'b0, 8'd0);
    tbl[7]  = mkv(1'b0, mk_r(5'd5, 5'd5, 5'd9, 5'd1, 6'h2A), 1'b0, 1'b0, 5'd0, 32'h0,
                  1'b0, 32'h1234_5678, 32'h1234_5678, 6'h2A, 5'd1, 5'd9, 1'b0, 8'd0);
    tbl[8]  = mkv(1'b1, LW, 1'b0, 1'b0, 5'd0, 32'h0,
                  1'b0, 32'h0, 32'h0, 6'h04, 5'd0, 5'd0, 1'b1, 8'd1);
    tbl[9]  = mkv(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                  1'b0, 32'h0, 32'h0, 6'h00, 5'd0, 5'd0, 1'b0, 8'd1);
    tbl[10] = mkv(1'b0, LW, 1'b0, 1'b0, 5'd0, 32'h0,
                  1'b0, 32'h0, 32'h0, 6'h04, 5'd0, 5'd0, 1'b0, 8'd1);
    tbl[11] = mkv(1'b1, mk_r(5'd0, 5'd5, 5'd10, 5'd0, 6'h20), 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF,
                  1'b1, 32'h0, 32'h1234_5678, 6'h20, 5'd0, 5'd10, 1'b0, 8'd1);
    tbl[12] = mkv(1'b0, 32'h0, 1'b0, 1'b1, 5'd9, 32'h1,
                  1'b0, 32'h0, 32'h0, 6'h00, 5'd0, 5'd0, 1'b0, 8'd1);
    tbl[13] = mkv(1'b1, mk_r(5'd9, 5'd5, 5'd11, 5'd3, 6'h20), 1'b0, 1'b0, 5'd0, 32'h0,
                  1'b1, 32'h1, 32'h1234_5678, 6'h20, 5'd3, 5'd11, 1'b0, 8'd1);
    tbl[14] = mkv(1'b1, LW, 1'b1, 1'b1, 5'd9, 32'h55,
                  1'b1, 32'h55, 32'h1234_5678, 6'h20, 5'd3, 5'd11, 1'b0, 8'd1);
    tbl[15] = mkv(1'b1, mk_r(5'd1, 5'd2, 5'd3, 5'd4, 6'h05), 1'b1, 1'b1, 5'd5, 32'hA5A5_A5A5,
                  1'b1, 32'h55, 32'hA5A5_A5A5, 6'h20, 5'd3, 5'd11, 1'b0, 8'd1);
    tbl[16] = mkv(1'b0, 32'h0, 1'b1, 1'b1, 5'd7, 32'h1,
                  1'b1, 32'h55, 32'hA5A5_A5A5, 6'h20, 5'd3, 5'd11, 1'b0, 8'd1);
    tbl[17] = mkv(1'b1, mk_r(5'd9, 5'd7, 5'd12, 5'd0, 6'h21), 1'b0, 1'b0, 5'd0, 32'h0,
                  1'b1, 32'h55, 32'h1, 6'h21, 5'd0, 5'd12, 1'b0, 8'd1);

    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    #12;
    check_all("reset", 1'b0, 32'h0, 32'h0, 6'h00, 5'd0, 5'd0, 1'b0, 8'd0);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].iv, tbl[i].ins, tbl[i].st, tbl[i].we, tbl[i].wa, tbl[i].wd);
      @(posedge clock); #1;
      check_all($sformatf("row%0d", i), tbl[i].e_valid, tbl[i].e_rs, tbl[i].e_rt,
                tbl[i].e_func, tbl[i].e_sa, tbl[i].e_rd, tbl[i].e_ill, tbl[i].e_cnt);
    end

    // 300 consecutive illegal instructions: count saturates, pulse persists
    exp_cnt = 8'd1;
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, LW, 1'b0, 1'b0, 5'd0, 32'h0);
      @(posedge clock); #1;
      if (exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
      check($sformatf("sat%0d illegal", k), {31'd0, illegal}, 32'd1);
      check($sformatf("sat%0d count", k), {24'd0, illegal_count}, {24'd0, exp_cnt});
    end
    check("sat final count", {24'd0, illegal_count}, 32'd255);
    drive(1'b1, mk_r(5'd5, 5'd6, 5'd1, 5'd0, 6'h20), 1'b0, 1'b0, 5'd0, 32'h0);
    @(posedge clock); #1;
    check_all("post-sat", 1'b1, 32'hA5A5_A5A5, 32'hFFFF_FFF9, 6'h20, 5'd0, 5'd1, 1'b0, 8'd255);

    // Asynchronous reset between edges while out_valid is high
    #2 reset = 1'b1;
    #1;
    check_all("async reset", 1'b0, 32'h0, 32'h0, 6'h00, 5'd0, 5'd0, 1'b0, 8'd0);
    #1 reset = 1'b0;
    drive(1'b1, mk_r(5'd5, 5'd6, 5'd2, 5'd0, 6'h20), 1'b0, 1'b0, 5'd0, 32'h0);
    @(posedge clock); #1;
    check_all("after reset", 1'b1, 32'h0, 32'h0, 6'h20, 5'd0, 5'd2, 1'b0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode and register-file stage of the MIPS pipeline, sitting directly upstream of the execute stage. Each cycle it accepts one 32-bit instruction, splits out the R-type fields and reads the two source registers from a 32×32 register file. It presents registered operand values and function code to execute one cycle later. The register file's write port is driven by the writeback stage, with same-cycle write-to-read bypass and stall-hold refresh.

## Interface
- DATA_W, 32, register and operand width.
- NREGS, 32, register count; address width is 5.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  instr is a valid instruction this cycle.
- instr  in  32  instruction word; opcode=instr[0:5], rs=[6:10], rt=[11:15], rd=[16:20], sa=[21:25], func=[26:31] (bit 0 = MSB).
- stall  in  1  downstream hold; output register keeps its contents.
- wb_en  in  1  register-file write enable.
- wb_addr  in  5  write address.
- wb_data  in  32  write data.
- out_valid  out  1  decoded R-type instruction present on outputs.
- rs_val  out  32  value of register rs.
- rt_val  out  32  value of register rt.
- func  out  6  function code, passed to execute.
- sa  out  5  shift amount.
- rd  out  5  destination register index.
- illegal  out  1  one-cycle pulse: a valid non-R-type instruction was dropped.
- illegal_count  out  8  saturating count of dropped instructions.

## Operation
- Register file: 32 entries × 32 bits. Register 0 reads 0 always; writes to address 0 are discarded. Write on rising clock when wb_en=1 and wb_addr≠0. Writes occur regardless of stall or in_valid.
- Read bypass: if wb_en=1, wb_addr≠0 and wb_addr equals the rs (or rt) field, the read returns wb_data, not the stored value.
- Accept (stall=0):
  - Output register loads rs_val, rt_val, func, sa, rd from instr.
  - out_valid ← in_valid AND (opcode=0).
  - Fields load even when out_valid becomes 0; execute must ignore them.
- Illegal: in_valid=1, opcode≠0 and stall=0 → illegal=1 for exactly one cycle, out_valid=0, illegal_count increments and saturates at 255. Otherwise illegal=0.
- Stall (stall=1):
  - out_valid, func, sa and rd hold; instr and in_valid are ignored; illegal=0. Upstream holds its instruction.
  - Stall refresh: if wb_en=1, wb_addr≠0 and wb_addr equals the held rs index, rs_val ← wb_data (same for rt). The held rs and rt indices are stored internally alongside the outputs for this purpose.
  - No other output changes while stalled.
- Reset (asynchronous, any time, including mid-stall):
  - All register-file entries → 0.
  - out_valid=0, rs_val=0, rt_val=0, func=0, sa=0, rd=0, illegal=0, illegal_count=0.
  - Held indices → 0.
  - The first accept is on the first rising edge after reset deasserts.

## Timing
- Latency: instr at edge N → outputs valid after edge N+1 (1 cycle). Throughput is 1 instruction/cycle when stall=0.
- Write and read of the same register in the same cycle: the new value is forwarded. A stored write is visible to reads from the following cycle onward.
- stall is sampled on the same edge as instr. The stall=0 edge that ends a stall loads the next instruction.
- wb_en with wb_addr=0: no effect on the file, bypass or refresh.
- illegal_count at 255 stays at 255 on further illegal instructions. illegal still pulses.

## Test plan
- Reset then write/read: wb r5=0x0000_0007, r6=0xFFFF_FFF9, then instr 0x00A6_3820 (add r7,r5,r6) → next cycle out_valid=1, rs_val=7, rt_val=0xFFFF_FFF9, func=0x20, rd=7.
- Bypass: in the same cycle, wb r5=0x1234_5678 and instr with rs=5 → rs_val=0x1234_5678 one cycle later.
- r0: wb_en=1, wb_addr=0, wb_data=0xDEAD_BEEF, then read rs=0, rt=0 → both 0.
- Stall refresh: issue rs=9 (r9=1), raise stall, wb r9=0x55 during stall → rs_val=0x55 while func/rd unchanged; drop stall → next instruction loads.
- Illegal: instr 0x8C22_0004 (lw) with in_valid=1 → illegal=1 one cycle, out_valid=0, illegal_count=1. 300 illegal instructions → count=255.
- Async reset mid-stream: assert reset between edges with out_valid=1 → all outputs 0 immediately. A subsequent read of r5 returns 0.
